// File: rtl/topo_grid.sv
// rtl/topo_grid.sv - registered whack-a-mole playfield with per-cell mole FSMs, score and miss bookkeeping
module topo_grid #(
    parameter int N_CELLS     = 9,
    parameter int IDX_W       = 4,
    parameter int LIFE_TICKS  = 8,
    parameter int FLASH_TICKS = 2,
    parameter int MAX_ACTIVE  = 3,
    parameter int SCORE_W     = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   spawn_valid,
    input  logic [IDX_W-1:0]       spawn_idx,
    input  logic [IDX_W-1:0]       select_idx,
    input  logic                   golpe,
    output logic                   spawn_ack,
    output logic                   spawn_nack,
    output logic                   hit,
    output logic                   whiff,
    output logic                   miss,
    output logic [SCORE_W-1:0]     score,
    output logic [SCORE_W-1:0]     miss_count,
    output logic [IDX_W-1:0]       active,
    output logic [3*N_CELLS-1:0]   rgb
);

    typedef enum logic [1:0] {
        CELL_IDLE  = 2'd0,
        CELL_UP    = 2'd1,
        CELL_FLASH = 2'd2
    } cell_state_t;

    localparam int T_MAX = (LIFE_TICKS > FLASH_TICKS) ? LIFE_TICKS : FLASH_TICKS;
    localparam int TMR_W = $clog2(T_MAX + 1);
    localparam logic [TMR_W-1:0] LIFE_INIT  = TMR_W'(LIFE_TICKS);
    localparam logic [TMR_W-1:0] FLASH_INIT = TMR_W'(FLASH_TICKS);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [IDX_W-1:0] MAX_A      = IDX_W'(MAX_ACTIVE);

    localparam logic [2:0] C_RED    = 3'b100;
    localparam logic [2:0] C_YELLOW = 3'b110;
    localparam logic [2:0] C_BLUE   = 3'b001;
    localparam logic [2:0] C_GREEN  = 3'b010;

    cell_state_t      state_q [N_CELLS];
    cell_state_t      state_d [N_CELLS];
    logic [TMR_W-1:0] timer_q [N_CELLS];
    logic [TMR_W-1:0] timer_d [N_CELLS];
    logic             golpe_q;

    logic [N_CELLS-1:0] spawn_here;
    logic [N_CELLS-1:0] sel_here;
    logic [N_CELLS-1:0] up_now;
    logic [N_CELLS-1:0] idle_now;
    logic [N_CELLS-1:0] expire;

    logic                 golpe_edge;
    logic                 hit_d;
    logic                 whiff_d;
    logic                 spawn_ok;
    logic                 miss_d;
    logic [IDX_W-1:0]     active_d;
    logic [IDX_W-1:0]     expired_n;
    logic [SCORE_W-1:0]   score_d;
    logic [SCORE_W-1:0]   miss_count_d;
    logic [SCORE_W:0]     miss_sum;
    logic [3*N_CELLS-1:0] rgb_d;

    // Index decode by equality keeps out-of-range indices from ever touching a cell.
    always_comb begin
        spawn_here = '0;
        sel_here   = '0;
        up_now     = '0;
        idle_now   = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            spawn_here[i] = (spawn_idx == IDX_W'(i));
            sel_here[i]   = (select_idx == IDX_W'(i));
            up_now[i]     = (state_q[i] == CELL_UP);
            idle_now[i]   = (state_q[i] == CELL_IDLE);
        end
    end

    // Spawn admission uses the UP count at t, so same-cycle timeouts or hits free no slot.
    always_comb begin
        golpe_edge = golpe & ~golpe_q;
        hit_d      = golpe_edge & (|(sel_here & up_now));
        whiff_d    = golpe_edge & ~hit_d;
        spawn_ok   = spawn_valid & (|(spawn_here & idle_now)) & (active < MAX_A);
    end

    always_comb begin
        expire = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            case (state_q[i])
                CELL_IDLE: begin
                    if (spawn_ok && spawn_here[i]) begin
                        state_d[i] = CELL_UP;
                        timer_d[i] = LIFE_INIT;
                    end
                end
                CELL_UP: begin
                    // A hit outranks a timeout landing on the same cycle.
                    if (hit_d && sel_here[i]) begin
                        state_d[i] = CELL_FLASH;
                        timer_d[i] = FLASH_INIT;
                    end else if (tick) begin
                        if (timer_q[i] == TMR_ONE) begin
                            state_d[i] = CELL_IDLE;
                            timer_d[i] = '0;
                            expire[i]  = 1'b1;
                        end else begin
                            timer_d[i] = timer_q[i] - TMR_ONE;
                        end
                    end
                end
                CELL_FLASH: begin
                    if (tick) begin
                        if (timer_q[i] == TMR_ONE) begin
                            state_d[i] = CELL_IDLE;
                            timer_d[i] = '0;
                        end else begin
                            timer_d[i] = timer_q[i] - TMR_ONE;
                        end
                    end
                end
                default: begin
                    state_d[i] = CELL_IDLE;
                    timer_d[i] = '0;
                end
            endcase
        end
    end

    always_comb begin
        active_d  = '0;
        expired_n = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            active_d  = active_d + IDX_W'(state_d[i] == CELL_UP);
            expired_n = expired_n + IDX_W'(expire[i]);
        end
        miss_d = |expire;

        score_d = score;
        if (hit_d && (score != {SCORE_W{1'b1}})) begin
            score_d = score + SCORE_W'(1);
        end

        miss_sum     = {1'b0, miss_count} + (SCORE_W+1)'(expired_n);
        miss_count_d = miss_sum[SCORE_W] ? {SCORE_W{1'b1}} : miss_sum[SCORE_W-1:0];
    end

    always_comb begin
        rgb_d = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (state_d[i] == CELL_FLASH) begin
                rgb_d[3*i +: 3] = C_RED;
            end else if (sel_here[i]) begin
                rgb_d[3*i +: 3] = C_YELLOW;
            end else if (state_d[i] == CELL_UP) begin
                rgb_d[3*i +: 3] = C_BLUE;
            end else begin
                rgb_d[3*i +: 3] = C_GREEN;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_CELLS; i++) begin
                state_q[i] <= CELL_IDLE;
                timer_q[i] <= '0;
            end
            golpe_q    <= 1'b0;
            spawn_ack  <= 1'b0;
            spawn_nack <= 1'b0;
            hit        <= 1'b0;
            whiff      <= 1'b0;
            miss       <= 1'b0;
            score      <= '0;
            miss_count <= '0;
            active     <= '0;
            rgb        <= {N_CELLS{C_GREEN}};
        end else begin
            for (int i = 0; i < N_CELLS; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
            golpe_q    <= golpe;
            spawn_ack  <= spawn_ok;
            spawn_nack <= spawn_valid & ~spawn_ok;
            hit        <= hit_d;
            whiff      <= whiff_d;
            miss       <= miss_d;
            score      <= score_d;
            miss_count <= miss_count_d;
            active     <= active_d;
            rgb        <= rgb_d;
        end
    end

endmodule

// File: tb/tb_topo_grid.sv
// tb/tb_topo_grid.sv - self-checking bench for topo_grid: vector table, directed corner sequences, randomized model comparison
module tb_topo_grid;

    localparam int N    = 9;
    localparam int IW   = 4;
    localparam int LIFE = 8;
    localparam int FL   = 2;
    localparam int MAXA = 3;
    localparam int SW   = 8;

    logic            clock = 1'b0;
    logic            reset;
    logic            tick;
    logic            spawn_valid;
    logic [IW-1:0]   spawn_idx;
    logic [IW-1:0]   select_idx;
    logic            golpe;
    logic            spawn_ack;
    logic            spawn_nack;
    logic            hit;
    logic            whiff;
    logic            miss;
    logic [SW-1:0]   score;
    logic [SW-1:0]   miss_count;
    logic [IW-1:0]   active;
    logic [3*N-1:0]  rgb;

    topo_grid #(
        .N_CELLS(N), .IDX_W(IW), .LIFE_TICKS(LIFE), .FLASH_TICKS(FL),
        .MAX_ACTIVE(MAXA), .SCORE_W(SW)
    ) dut (
        .clock(clock), .reset(reset), .tick(tick),
        .spawn_valid(spawn_valid), .spawn_idx(spawn_idx), .select_idx(select_idx),
        .golpe(golpe), .spawn_ack(spawn_ack), .spawn_nack(spawn_nack),
        .hit(hit), .whiff(whiff), .miss(miss), .score(score),
        .miss_count(miss_count), .active(active), .rgb(rgb)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: kind 0 = empty, 1 = mole up, 2 = flashing; left = ticks remaining.
    int   m_kind [N];
    int   m_left [N];
    logic m_gq;
    int   m_score;
    int   m_mc;

    logic            e_ack, e_nack, e_hit, e_whiff, e_miss;
    logic [SW-1:0]   e_score, e_mc;
    logic [IW-1:0]   e_active;
    logic [3*N-1:0]  e_rgb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic sv, input int sidx, input int sel,
                              input logic g, input logic tk);
        int   up_before;
        int   hit_cell;
        int   expired;
        int   up_after;
        logic edge_ev;
        logic acc;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_kind[i] = 0;
                m_left[i] = 0;
            end
            m_gq = 1'b0;
            m_score = 0;
            m_mc = 0;
            {e_ack, e_nack, e_hit, e_whiff, e_miss} = 5'b0;
            e_score = '0;
            e_mc = '0;
            e_active = '0;
            e_rgb = {N{3'b010}};
        end else begin
            up_before = 0;
            for (int i = 0; i < N; i++) if (m_kind[i] == 1) up_before++;
            edge_ev = g && !m_gq;
            m_gq = g;
            hit_cell = -1;
            if (edge_ev && sel < N) begin
                if (m_kind[sel] == 1) hit_cell = sel;
            end
            acc = 1'b0;
            if (sv && sidx < N) begin
                if (m_kind[sidx] == 0 && up_before < MAXA) acc = 1'b1;
            end
            expired = 0;
            for (int i = 0; i < N; i++) begin
                if (i == hit_cell) begin
                    m_kind[i] = 2;
                    m_left[i] = FL;
                end else if (m_kind[i] != 0 && tk) begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) begin
                        if (m_kind[i] == 1) expired++;
                        m_kind[i] = 0;
                    end
                end
            end
            if (acc) begin
                m_kind[sidx] = 1;
                m_left[sidx] = LIFE;
            end
            if (hit_cell >= 0 && m_score < 255) m_score++;
            m_mc = m_mc + expired;
            if (m_mc > 255) m_mc = 255;
            up_after = 0;
            for (int i = 0; i < N; i++) begin
                if (m_kind[i] == 1) up_after++;
                if (m_kind[i] == 2)      e_rgb[3*i +: 3] = 3'b100;
                else if (i == sel)       e_rgb[3*i +: 3] = 3'b110;
                else if (m_kind[i] == 1) e_rgb[3*i +: 3] = 3'b001;
                else                     e_rgb[3*i +: 3] = 3'b010;
            end
            e_ack = acc;
            e_nack = sv && !acc;
            e_hit = (hit_cell >= 0);
            e_whiff = edge_ev && (hit_cell < 0);
            e_miss = (expired > 0);
            e_score = SW'(m_score);
            e_mc = SW'(m_mc);
            e_active = IW'(up_after);
        end
    endtask

    task automatic cycle(input logic rst, input logic sv, input int sidx, input int sel,
                         input logic g, input logic tk);
        reset = rst;
        spawn_valid = sv;
        spawn_idx = IW'(sidx);
        select_idx = IW'(sel);
        golpe = g;
        tick = tk;
        @(posedge clock);
        #1;
        model_step(rst, sv, sidx, sel, g, tk);
        check("model", {spawn_ack, spawn_nack, hit, whiff, miss, score, miss_count, active, rgb},
                       {e_ack, e_nack, e_hit, e_whiff, e_miss, e_score, e_mc, e_active, e_rgb});
    endtask

    task automatic one_hit_cycle();
        cycle(0, 1, 0, 15, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 15, 0, 1);
        cycle(0, 0, 0, 15, 0, 1);
    endtask

    typedef struct {
        logic       sv;
        int         sidx;
        int         sel;
        logic       g;
        logic       tk;
        logic [4:0] pulses;
        int         score;
        int         active;
    } vec_t;

    vec_t tbl [11];
    int   hits_seen;
    int   whiffs_seen;
    logic rg;

    initial begin
        // pulses = {ack, nack, hit, whiff, miss}
        tbl[0]  = '{1'b1, 2, 15, 1'b0, 1'b0, 5'b10000, 0, 1};
        tbl[1]  = '{1'b0, 0,  2, 1'b1, 1'b0, 5'b00100, 1, 0};
        tbl[2]  = '{1'b0, 0,  2, 1'b1, 1'b0, 5'b00000, 1, 0};
        tbl[3]  = '{1'b0, 0,  5, 1'b0, 1'b0, 5'b00000, 1, 0};
        tbl[4]  = '{1'b0, 0,  5, 1'b1, 1'b0, 5'b00010, 1, 0};
        tbl[5]  = '{1'b1, 9, 15, 1'b1, 1'b0, 5'b01000, 1, 0};
        tbl[6]  = '{1'b1, 4, 15, 1'b0, 1'b0, 5'b10000, 1, 1};
        tbl[7]  = '{1'b1, 4, 15, 1'b0, 1'b0, 5'b01000, 1, 1};
        tbl[8]  = '{1'b1, 0, 15, 1'b0, 1'b0, 5'b10000, 1, 2};
        tbl[9]  = '{1'b1, 1, 15, 1'b0, 1'b0, 5'b10000, 1, 3};
        tbl[10] = '{1'b1, 3, 15, 1'b0, 1'b0, 5'b01000, 1, 3};

        for (int k = 0; k < 3; k++) begin
            cycle(1, 1, 2, 2, logic'(k % 2), 1);
            check("rst_rgb", rgb, {N{3'b010}});
            check("rst_pulses", {spawn_ack, spawn_nack, hit, whiff, miss}, 5'b0);
            check("rst_counters", {score, miss_count, active}, '0);
        end
        cycle(0, 0, 0, 15, 0, 0);

        for (int r = 0; r < 11; r++) begin
            cycle(0, tbl[r].sv, tbl[r].sidx, tbl[r].sel, tbl[r].g, tbl[r].tk);
            check($sformatf("vec%0d_pulses", r), {spawn_ack, spawn_nack, hit, whiff, miss}, tbl[r].pulses);
            check($sformatf("vec%0d_score", r), score, tbl[r].score);
            check($sformatf("vec%0d_active", r), active, tbl[r].active);
        end

        // cell 2 has been flashing since vec1: red for two ticks, then green
        cycle(0, 0, 0, 15, 0, 1);
        check("flash_tick1", rgb[8:6], 3'b100);
        cycle(0, 0, 0, 15, 0, 1);
        check("flash_tick2", rgb[8:6], 3'b010);

        cycle(1, 0, 0, 15, 0, 0);
        cycle(0, 1, 4, 15, 0, 0);
        for (int k = 1; k <= LIFE; k++) begin
            cycle(0, 0, 0, 15, 0, 1);
            if (k < LIFE) check("timeout_early", miss, 1'b0);
        end
        check("timeout_miss", miss, 1'b1);
        check("timeout_count", miss_count, 1);
        check("timeout_active", active, 0);
        check("timeout_rgb", rgb[14:12], 3'b010);
        cycle(0, 0, 0, 15, 0, 0);
        check("miss_pulse_len", miss, 1'b0);

        cycle(0, 1, 1, 15, 0, 0);
        for (int k = 0; k < LIFE - 1; k++) cycle(0, 0, 0, 15, 0, 1);
        cycle(0, 0, 0, 1, 1, 1);
        check("last_tick_hit", hit, 1'b1);
        check("last_tick_no_miss", miss, 1'b0);
        check("last_tick_misscount", miss_count, 1);
        check("last_tick_score", score, 1);
        cycle(0, 0, 0, 15, 0, 0);

        cycle(0, 1, 6, 15, 0, 0);
        hits_seen = 0;
        whiffs_seen = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(0, 0, 0, 6, 1, 0);
            if (hit) hits_seen++;
            if (whiff) whiffs_seen++;
        end
        check("held_golpe_hits", hits_seen, 1);
        check("held_golpe_whiffs", whiffs_seen, 0);
        cycle(0, 0, 0, 15, 0, 0);
        cycle(0, 0, 0, 7, 1, 0);
        check("idle_whiff", whiff, 1'b1);
        check("idle_no_hit", hit, 1'b0);
        check("idle_score", score, 2);
        cycle(0, 0, 0, 15, 0, 0);

        cycle(1, 0, 0, 15, 0, 0);
        for (int h = 0; h < 254; h++) one_hit_cycle();
        check("sat_pre", score, 254);
        cycle(0, 1, 0, 15, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("sat_reach", score, 255);
        cycle(0, 0, 0, 15, 0, 1);
        cycle(0, 0, 0, 15, 0, 1);
        cycle(0, 1, 0, 15, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("sat_hit_pulse", hit, 1'b1);
        check("sat_hold", score, 255);
        cycle(0, 0, 0, 15, 0, 1);
        cycle(0, 0, 0, 15, 0, 1);

        rg = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 2) == 0) rg = ~rg;
            cycle(logic'($urandom_range(0, 249) == 0),
                  logic'($urandom_range(0, 1)),
                  int'($urandom_range(0, 10)),
                  int'($urandom_range(0, 11)),
                  rg,
                  logic'($urandom_range(0, 9) < 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
